regfft_reader: RTL

- Read-side sequencer for the 64x38 FFT input register bank.
- After software or the loader has filled the bank, a start pulse makes this block read every entry in natural or bit-reversed order.
- It streams the words to the FFT core over a valid/ready interface and absorbs the bank's one-cycle read latency and downstream backpressure.
- It sits between the regfft bank and the FFT datapath. A top-level mux routes its address to the bank while busy=1.

---
 rtl/regfft_pkg.sv | 27 ++
 rtl/regfft_skid2.sv | 62 ++++++
 rtl/regfft_reader.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfft_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfft_pkg : shared FFT bank constants, reader FSM states, bitrev. |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package regfft_pkg;

   localparam int FFT_DEPTH  = 64;
   localparam int FFT_ADDR_W = 6;
   localparam int FFT_DATA_W = 38;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   function automatic logic [FFT_ADDR_W-1:0] bitrev6(input logic [FFT_ADDR_W-1:0] i_a);
      logic [FFT_ADDR_W-1:0] v_r;
      for (int b = 0; b < FFT_ADDR_W; b++) begin
         v_r[b] = i_a[FFT_ADDR_W-1-b];
      end
      return v_r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfft_skid2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfft_skid2 : 2-entry first-word-fall-through valid/ready FIFO.   |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module regfft_skid2 #(
   parameter int DATA_W = 38
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic              w_empty;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;

   // When empty, arriving data is presented directly and only stored if not taken.
   assign w_empty  = (r_count == 2'd0);
   assign o_valid  = !w_empty || i_valid;
   assign o_data   = w_empty ? i_data : r_mem[r_rptr];
   assign o_count  = r_count;
   assign w_bypass = w_empty && i_valid && i_ready;
   assign w_push   = i_valid && !w_bypass;
   assign w_pop    = !w_empty && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfft_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfft_reader : streams one 64-entry bank frame to the FFT core.   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module regfft_reader
   import regfft_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W,
   parameter int ADDR_W = FFT_ADDR_W,
   parameter int DEPTH  = FFT_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              bitrev_en,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              regfft_wren,
   output logic [ADDR_W-1:0] regfft_addr,
   input  logic [DATA_W-1:0] regfft_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last
);

   localparam logic [ADDR_W:0] c_last = (ADDR_W+1)'(DEPTH - 1);

   rd_state_t         r_state;
   rd_state_t         w_next;
   logic [ADDR_W:0]   r_icnt;
   logic [ADDR_W:0]   r_ocnt;
   logic              r_bitrev;
   logic              r_inflight;
   logic              r_done;
   logic [1:0]        w_count;
   logic              w_sk_valid;
   logic [DATA_W-1:0] w_sk_data;
   logic              w_hs;
   logic [2:0]        w_occ;
   logic              w_issue;
   logic              w_accept;

   regfft_skid2 #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (abort),
      .i_valid (r_inflight),
      .i_data  (regfft_rdata),
      .i_ready (out_ready),
      .o_valid (w_sk_valid),
      .o_data  (w_sk_data),
      .o_count (w_count)
   );

   // A handshake this cycle frees a slot, so steady-state streaming needs no bubble.
   assign w_hs     = w_sk_valid && out_ready;
   assign w_occ    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_hs};
   assign w_issue  = (r_state == ST_READ) && (w_occ < 3'd2) && !abort;
   assign w_accept = (r_state == ST_IDLE) && start && !abort;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_READ;
         ST_READ:  if (w_issue && (r_icnt == c_last)) w_next = ST_DRAIN;
         ST_DRAIN: if (w_hs && (r_ocnt == c_last)) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (abort) w_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_icnt     <= '0;
         r_ocnt     <= '0;
         r_bitrev   <= 1'b0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_issue;
         r_done     <= (r_state == ST_DRAIN) && w_hs && (r_ocnt == c_last) && !abort;
         if (abort || w_accept) begin
            r_icnt <= '0;
            r_ocnt <= '0;
         end else begin
            if (w_issue) r_icnt <= r_icnt + 1'b1;
            if (w_hs)    r_ocnt <= r_ocnt + 1'b1;
         end
         if (w_accept) r_bitrev <= bitrev_en;
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign regfft_wren = 1'b0;
   assign regfft_addr = (r_state != ST_READ) ? '0 :
                        r_bitrev ? bitrev6(r_icnt[ADDR_W-1:0]) : r_icnt[ADDR_W-1:0];
   assign out_valid   = w_sk_valid;
   assign out_data    = w_sk_valid ? w_sk_data : '0;
   assign out_index   = r_ocnt[ADDR_W-1:0];
   assign out_last    = w_sk_valid && (r_ocnt[ADDR_W-1:0] == c_last[ADDR_W-1:0]);

endmodule
`default_nettype wire
